// File: rtl/im_byte_loader.sv
// im_byte_loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory while holding the CPU in reset
module im_byte_loader #(
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              finish,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic [ADDR_W:0]   word_count,
    output logic              full
);
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE} state_t;
    state_t state_q, state_d;
    logic [1:0] lane_q, lane_d;
    logic [31:0] word_q, word_d, merged;
    logic [31:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic fin_q, fin_d, rel_q, rel_d;
    logic ready_q, ready_d, we_q, we_d, cpu_q, cpu_d, busy_q, busy_d, full_q, full_d;
    logic acc, last;
    assign byte_ready = ready_q;
    assign im_we      = we_q;
    assign im_addr    = addr_q;
    assign im_wdata   = wdata_q;
    assign cpu_rst    = cpu_q;
    assign busy       = busy_q;
    assign word_count = cnt_q;
    assign full       = full_q;
    assign acc    = byte_valid & ready_q;
    assign merged = acc ? word_q | ({24'd0, byte_data} << {lane_q, 3'd0}) : word_q;
    // word_count doubles as the write pointer; last means this write fills memory
    assign last   = cnt_q == {1'b0, {ADDR_W{1'b1}}};
    // Next-state and next-output logic; rel_q releases the CPU one cycle after busy falls
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        word_d  = word_q;
        fin_d   = fin_q;
        rel_d   = 1'b0;
        ready_d = ready_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cpu_d   = rel_q ? 1'b0 : cpu_q;
        busy_d  = busy_q;
        full_d  = full_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = COLLECT;
                lane_d  = 2'd0;
                word_d  = 32'd0;
                fin_d   = 1'b0;
                cnt_d   = '0;
                full_d  = 1'b0;
                busy_d  = 1'b1;
                ready_d = 1'b1;
                cpu_d   = 1'b1;
            end
            COLLECT: begin
                word_d = merged;
                lane_d = lane_q + 2'(acc);
                if ((acc && lane_q == 2'd3) || (finish && (acc || lane_q != 2'd0))) begin
                    state_d = WRITE;
                    ready_d = 1'b0;
                    fin_d   = finish;
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = merged;
                end else if (finish) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b0;
                    rel_d   = 1'b1;
                end
            end
            WRITE: begin
                cnt_d  = cnt_q + (ADDR_W+1)'(1);
                word_d = 32'd0;
                lane_d = 2'd0;
                if (last || fin_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    ready_d = 1'b0;
                    rel_d   = 1'b1;
                    full_d  = last;
                end else begin
                    state_d = COLLECT;
                    ready_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lane_q  <= 2'd0;
            word_q  <= 32'd0;
            fin_q   <= 1'b0;
            rel_q   <= 1'b0;
            ready_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            cpu_q   <= 1'b1;
            busy_q  <= 1'b0;
            full_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            word_q  <= word_d;
            fin_q   <= fin_d;
            rel_q   <= rel_d;
            ready_q <= ready_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cpu_q   <= cpu_d;
            busy_q  <= busy_d;
            full_q  <= full_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule
